// File: rtl/tracker_pkg.sv
// tracker_pkg: shared types for the multi-channel signal tracker.
package tracker_pkg;
   typedef enum logic [1:0] {OK = 2'd0, OPEN = 2'd1, NO_START = 2'd2, ERR_DEPTH = 2'd3} tracker_status_t;
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, RESP = 2'd2} tracker_state_t;
   typedef struct packed {
      logic tracked;
      logic corrob;
   } hist_entry_t;
endpackage

// File: rtl/tracker_history_buffer.sv
// tracker_history_buffer: one channel's circular history with write pointer, saturating fill count and an indexed read port.
module tracker_history_buffer
   import tracker_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        wr_en_i,
   input  hist_entry_t wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output hist_entry_t rd_data_o,
   output logic [AW-1:0] wr_ptr_o,
   output logic [AW:0]   valid_cnt_o
);
   hist_entry_t   mem_q [DEPTH];
   logic [AW-1:0] ptr_q;
   logic [AW:0]   cnt_q;

   assign rd_data_o   = mem_q[rd_addr_i];
   assign wr_ptr_o    = ptr_q;
   assign valid_cnt_o = cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_q <= '{default: '0};
         ptr_q <= '0;
         cnt_q <= '0;
      end else if (wr_en_i) begin
         mem_q[ptr_q] <= wr_data_i;
         ptr_q        <= ptr_q + AW'(1);
         cnt_q        <= (cnt_q == (AW+1)'(DEPTH)) ? cnt_q : cnt_q + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/multi_channel_signal_tracker.sv
// multi_channel_signal_tracker: per-channel sample history with a handshaked
// "first active interval in the newest N samples" query engine.
module multi_channel_signal_tracker
   import tracker_pkg::*;
#(
   parameter int NUM_CHANNELS               = 4,
   parameter int TRACKED_SIGNAL_WIDTH       = 1,
   parameter int CORROBORATING_SIGNAL_WIDTH = 1,
   parameter int BUFFER_DEPTH               = 16,
   parameter int TIME_WIDTH                 = 32
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                sample_en,
   input  logic [NUM_CHANNELS*TRACKED_SIGNAL_WIDTH-1:0]        tracked_signal,
   input  logic [NUM_CHANNELS*CORROBORATING_SIGNAL_WIDTH-1:0]  corroborating_signal,
   input  logic                                                query_valid,
   output logic                                                query_ready,
   input  logic [$clog2(NUM_CHANNELS)-1:0]                     query_channel,
   input  logic [$clog2(BUFFER_DEPTH):0]                       query_depth,
   output logic                                                resp_valid,
   input  logic                                                resp_ready,
   output logic [1:0]                                          resp_status,
   output logic [TIME_WIDTH-1:0]                               resp_start,
   output logic [TIME_WIDTH-1:0]                               resp_end,
   input  logic                                                end_update_valid,
   input  logic [$clog2(NUM_CHANNELS)-1:0]                     end_update_channel,
   input  logic [TIME_WIDTH-1:0]                               end_update_value,
   output logic [TIME_WIDTH-1:0]                               sample_count
);
   localparam int CW  = $clog2(NUM_CHANNELS);
   localparam int AW  = $clog2(BUFFER_DEPTH);
   localparam int DW  = AW + 1;
   localparam int TSW = TRACKED_SIGNAL_WIDTH;
   localparam int CSW = CORROBORATING_SIGNAL_WIDTH;

   hist_entry_t     wr_w   [NUM_CHANNELS];
   hist_entry_t     rd_w   [NUM_CHANNELS];
   logic [AW-1:0]   ptr_w  [NUM_CHANNELS];
   logic [DW-1:0]   vcnt_w [NUM_CHANNELS];
   logic [AW-1:0]   scan_addr;

   tracker_state_t  state_q, state_d;
   tracker_status_t status_q, status_d;
   logic            alive_q;
   logic [CW-1:0]   chan_q, chan_d;
   logic [DW-1:0]   depth_q, depth_d, idx_q, idx_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [TIME_WIDTH-1:0] snap_q, snap_d, start_q, start_d, end_q, end_d;
   logic            found_q, found_d, cas_q, cas_d;
   logic [TIME_WIDTH-1:0] prev_end_q [NUM_CHANNELS];
   logic [TIME_WIDTH-1:0] prev_end_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] prev_vld_q, prev_vld_d;
   logic [TIME_WIDTH-1:0] sample_cnt_q;

   hist_entry_t           ent;
   logic [TIME_WIDTH-1:0] ts, end_ts;
   logic                  last, depth_ok, start_hit, end_hit, scan_upd;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      assign wr_w[c] = {|tracked_signal[c*TSW +: TSW], |corroborating_signal[c*CSW +: CSW]};
      tracker_history_buffer #(.DEPTH(BUFFER_DEPTH)) u_buf (
         .clk_i      (clk),
         .rst_n_i    (rst),
         .wr_en_i    (sample_en),
         .wr_data_i  (wr_w[c]),
         .rd_addr_i  (scan_addr),
         .rd_data_o  (rd_w[c]),
         .wr_ptr_o   (ptr_w[c]),
         .valid_cnt_o(vcnt_w[c])
      );
   end

   assign query_ready  = alive_q && (state_q == IDLE);
   assign resp_valid   = (state_q == RESP);
   assign resp_status  = status_q;
   assign resp_start   = start_q;
   assign resp_end     = end_q;
   assign sample_count = sample_cnt_q;

   // Entry i of the scan window sits depth-i slots behind the snapshotted write pointer.
   assign scan_addr = ptr_q - depth_q[AW-1:0] + idx_q[AW-1:0];
   assign ent       = rd_w[chan_q];
   assign ts        = snap_q - TIME_WIDTH'(depth_q) + TIME_WIDTH'(idx_q);
   assign last      = (idx_q == depth_q - DW'(1));
   assign depth_ok  = (query_depth != '0) && (query_depth <= vcnt_w[query_channel])
                   && (query_depth <= DW'(BUFFER_DEPTH/2));
   assign start_hit = ent.tracked && (!prev_vld_q[chan_q] || ts > prev_end_q[chan_q]);
   assign end_hit   = !ent.tracked || (cas_q != ent.corrob);
   assign end_ts    = (!ent.tracked || cas_q) ? ts - TIME_WIDTH'(1) : ts;

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      chan_d   = chan_q;
      depth_d  = depth_q;
      ptr_d    = ptr_q;
      snap_d   = snap_q;
      idx_d    = idx_q;
      found_d  = found_q;
      cas_d    = cas_q;
      start_d  = start_q;
      end_d    = end_q;
      scan_upd = 1'b0;
      case (state_q)
         IDLE: if (query_valid && query_ready) begin
            chan_d   = query_channel;
            depth_d  = query_depth;
            ptr_d    = ptr_w[query_channel];
            snap_d   = sample_cnt_q;
            idx_d    = '0;
            found_d  = 1'b0;
            start_d  = '0;
            end_d    = '0;
            state_d  = depth_ok ? SCAN : RESP;
            status_d = depth_ok ? NO_START : ERR_DEPTH;
         end
         SCAN: begin
            idx_d = idx_q + DW'(1);
            if (!found_q) begin
               found_d  = start_hit;
               cas_d    = ent.corrob;
               start_d  = start_hit ? ts : '0;
               status_d = start_hit ? OPEN : NO_START;
               state_d  = last ? RESP : SCAN;
            end else if (end_hit) begin
               end_d    = end_ts;
               status_d = OK;
               state_d  = RESP;
               scan_upd = 1'b1;
            end else begin
               state_d  = last ? RESP : SCAN;
            end
         end
         RESP: state_d = resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   // An external override lands after the scan update so it wins on a same-channel collision.
   always_comb begin
      prev_end_d = prev_end_q;
      prev_vld_d = prev_vld_q;
      if (scan_upd) begin
         prev_end_d[chan_q] = end_ts;
         prev_vld_d[chan_q] = 1'b1;
      end
      if (end_update_valid) begin
         prev_end_d[end_update_channel] = end_update_value;
         prev_vld_d[end_update_channel] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         status_q     <= OK;
         alive_q      <= 1'b0;
         chan_q       <= '0;
         depth_q      <= '0;
         ptr_q        <= '0;
         snap_q       <= '0;
         idx_q        <= '0;
         found_q      <= 1'b0;
         cas_q        <= 1'b0;
         start_q      <= '0;
         end_q        <= '0;
         prev_end_q   <= '{default: '0};
         prev_vld_q   <= '0;
         sample_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         status_q     <= status_d;
         alive_q      <= 1'b1;
         chan_q       <= chan_d;
         depth_q      <= depth_d;
         ptr_q        <= ptr_d;
         snap_q       <= snap_d;
         idx_q        <= idx_d;
         found_q      <= found_d;
         cas_q        <= cas_d;
         start_q      <= start_d;
         end_q        <= end_d;
         prev_end_q   <= prev_end_d;
         prev_vld_q   <= prev_vld_d;
         sample_cnt_q <= sample_cnt_q + TIME_WIDTH'(sample_en);
      end
   end
endmodule
